tlx_sram_arb: RTL and testbench
===============================

TLX_SRAM_ARB -- requirements
Module: tlx_sram_arb

Interface
REQ-001 Parameter: ADDR_WIDTH, default 27, SRAM word-address width.
REQ-002 Parameter: DATA_WIDTH, default 64, SRAM data width; byte-enable width is DATA_WIDTH/8.
REQ-003 Parameter: MAX_BURST, default 16, maximum consecutive locked grants before forced hand-over.
REQ-004 Clock and reset ports SHALL be: CLK  in  1  single clock; RESET  in  1  asynchronous, active-high reset.
REQ-005 Requester ports, for i in {0,1}: Ri_REQ  in  1  access request.
REQ-006 Ri_LOCK  in  1  keep ownership after this access.
REQ-007 Ri_WRITE  in  1  1 = write, 0 = read.
REQ-008 Ri_ADDR  in  ADDR_WIDTH  word address.
REQ-009 Ri_WDATA  in  DATA_WIDTH  write data.
REQ-010 Ri_WBE  in  DATA_WIDTH/8  active-high byte enables.
REQ-011 Ri_GNT  out  1  access accepted this cycle.
REQ-012 Ri_RVALID  out  1  read data valid.
REQ-013 Ri_RDATA  out  DATA_WIDTH  read data.
REQ-014 SRAM ports: SRAM_CS  out  1  active-high select; SRAM_WE  out  DATA_WIDTH/8  active-high byte write enables; SRAM_ADDR  out  ADDR_WIDTH; SRAM_WDATA  out  DATA_WIDTH; SRAM_RDATA  in  DATA_WIDTH, valid one cycle after a read select.

Function
REQ-015 The block SHALL issue at most one SRAM access per cycle, to exactly one requester.
REQ-016 Ri_GNT SHALL be combinational in the request cycle; an access completes when Ri_REQ and Ri_GNT are both high.
REQ-017 On a grant, SRAM_CS=1, SRAM_ADDR/SRAM_WDATA come from the granted port, and SRAM_WE = Ri_WRITE ? Ri_WBE : 0.
REQ-018 With no grant, SRAM_CS and SRAM_WE SHALL be 0; SRAM_ADDR/SRAM_WDATA hold requester 0 values.
REQ-019 Ri_RVALID SHALL be registered and pulse for exactly one cycle, the cycle after a granted read to port i.
REQ-020 Ri_RDATA SHALL equal SRAM_RDATA; it is meaningful only while Ri_RVALID is high.
REQ-021 FSM states: IDLE, LOCK0, LOCK1.
REQ-022 In IDLE, a single requester SHALL be granted; on simultaneous requests, the port not recorded in last-served register LAST SHALL win.
REQ-023 On each grant, LAST SHALL update to the granted port.
REQ-024 A grant with Ri_LOCK=1 SHALL move IDLE to LOCKi.
REQ-025 In LOCKi, only port i SHALL be granted.
REQ-026 LOCKi SHALL return to IDLE when port i is granted with Ri_LOCK=0, or when port i drops Ri_REQ.
REQ-027 A burst counter SHALL clear on entry to LOCKi and increment on each granted cycle.
REQ-028 When the counter reaches MAX_BURST-1 on a grant and the other port requests, the FSM SHALL go to IDLE regardless of Ri_LOCK; LAST then forces hand-over.
REQ-029 The counter SHALL saturate and never wrap.
REQ-030 An ungranted request SHALL be held by the requester; the block does not buffer requests.

Reset
REQ-031 While RESET is high: FSM=IDLE, LAST=1 (port 0 wins first), counter=0, R0_RVALID=R1_RVALID=0, SRAM_CS=0, SRAM_WE=0.
REQ-032 A read granted in the cycle RESET asserts SHALL produce no RVALID; no state survives reset.

Structure
REQ-033 The FSM state encoding and the default parameter values SHALL live in the shared package tlx_sram_pkg.
REQ-034 The arbitration decision (IDLE/LAST priority) SHALL be a sub-module tlx_rr_arb2; the FSM, counter and RVALID pipeline stay in the top level.

Verification
REQ-035 Bench case 1: R0 read at address 0x10 alone. Required: R0_GNT=1, SRAM_CS=1, SRAM_WE=0x00, R0_RVALID=1 next cycle with the stored data.
REQ-036 Bench case 2: R0 and R1 write every cycle after reset. Required: grants alternate 0,1,0,1; SRAM_WE equals the granted WBE (0xFF/0x0F).
REQ-037 Bench case 3: R1 locks for 4 writes while R0 requests. Required: R0_GNT=0 for 4 cycles, R0 granted on the 5th.
REQ-038 Bench case 4: R0 holds LOCK for 20 cycles while R1 requests. Required: R1 granted in cycle 17, then R0 resumes.
REQ-039 Bench case 5: RESET asserted mid-burst in LOCK1 with a read in flight. Required: R1_RVALID=0, SRAM_CS=0 immediately; first post-reset contention goes to R0.

Source files
------------

// File: rtl/tlx_sram_pkg.sv
// Shared arbiter FSM encoding and default geometry for the two-port SRAM arbiter.
package tlx_sram_pkg;

    localparam int DEF_ADDR_WIDTH = 27;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_MAX_BURST  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/tlx_rr_arb2.sv
// Two-way arbiter: a lone request wins, and on contention the port not served last wins.
// Purely combinational, zero latency; a losing requester holds its request.
module tlx_rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt0,
    output logic gnt1
);

    assign gnt0 = req0 & (~req1 | last);
    assign gnt1 = req1 & (~req0 | ~last);

endmodule

// File: rtl/tlx_sram_arb.sv
// Two-requester SRAM arbiter with lock bursts and a bounded burst length.
// Grants are combinational in the request cycle; read valid follows one cycle later; losers hold requests.
module tlx_sram_arb
    import tlx_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    R0_REQ,
    input  logic                    R0_LOCK,
    input  logic                    R0_WRITE,
    input  logic [ADDR_WIDTH-1:0]   R0_ADDR,
    input  logic [DATA_WIDTH-1:0]   R0_WDATA,
    input  logic [DATA_WIDTH/8-1:0] R0_WBE,
    output logic                    R0_GNT,
    output logic                    R0_RVALID,
    output logic [DATA_WIDTH-1:0]   R0_RDATA,
    input  logic                    R1_REQ,
    input  logic                    R1_LOCK,
    input  logic                    R1_WRITE,
    input  logic [ADDR_WIDTH-1:0]   R1_ADDR,
    input  logic [DATA_WIDTH-1:0]   R1_WDATA,
    input  logic [DATA_WIDTH/8-1:0] R1_WBE,
    output logic                    R1_GNT,
    output logic                    R1_RVALID,
    output logic [DATA_WIDTH-1:0]   R1_RDATA,
    output logic                    SRAM_CS,
    output logic [DATA_WIDTH/8-1:0] SRAM_WE,
    output logic [ADDR_WIDTH-1:0]   SRAM_ADDR,
    output logic [DATA_WIDTH-1:0]   SRAM_WDATA,
    input  logic [DATA_WIDTH-1:0]   SRAM_RDATA
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    arb_state_t       state;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             burst_end;
    logic             rr_gnt0;
    logic             rr_gnt1;
    logic             gnt0;
    logic             gnt1;
    logic             rvalid0;
    logic             rvalid1;

    tlx_rr_arb2 u_rr (
        .req0 (R0_REQ),
        .req1 (R1_REQ),
        .last (last),
        .gnt0 (rr_gnt0),
        .gnt1 (rr_gnt1)
    );

    // Grants are masked by RESET so the SRAM sees no select while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!RESET) begin
            case (state)
                IDLE: begin
                    gnt0 = rr_gnt0;
                    gnt1 = rr_gnt1;
                end
                LOCK0:   gnt0 = R0_REQ;
                LOCK1:   gnt1 = R1_REQ;
                default: ;
            endcase
        end
    end

    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign burst_end = (cnt_inc == CNT_MAX);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            last    <= 1'b1;
            cnt     <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt0 & ~R0_WRITE;
            rvalid1 <= gnt1 & ~R1_WRITE;
            if (gnt0) begin
                last <= 1'b0;
            end else if (gnt1) begin
                last <= 1'b1;
            end
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (gnt0 && R0_LOCK) begin
                        state <= LOCK0;
                    end else if (gnt1 && R1_LOCK) begin
                        state <= LOCK1;
                    end
                end
                LOCK0: begin
                    if (!R0_REQ) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                        if (!R0_LOCK || (burst_end && R1_REQ)) begin
                            state <= IDLE;
                        end
                    end
                end
                LOCK1: begin
                    if (!R1_REQ) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                        if (!R1_LOCK || (burst_end && R0_REQ)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign R0_GNT     = gnt0;
    assign R1_GNT     = gnt1;
    assign R0_RVALID  = rvalid0;
    assign R1_RVALID  = rvalid1;
    assign R0_RDATA   = SRAM_RDATA;
    assign R1_RDATA   = SRAM_RDATA;
    assign SRAM_CS    = gnt0 | gnt1;
    assign SRAM_ADDR  = gnt1 ? R1_ADDR  : R0_ADDR;
    assign SRAM_WDATA = gnt1 ? R1_WDATA : R0_WDATA;
    assign SRAM_WE    = gnt1 ? (R1_WRITE ? R1_WBE : {BE_W{1'b0}}) :
                        gnt0 ? (R0_WRITE ? R0_WBE : {BE_W{1'b0}}) : {BE_W{1'b0}};

endmodule

// File: tb/tb_tlx_sram_arb.sv
// Directed bench for tlx_sram_arb: vector table plus hand-written lock-burst and reset sequences.
module tb_tlx_sram_arb;

    localparam logic [63:0] DA    = 64'hA5A5_0123_4567_89AB;
    localparam logic [63:0] DB    = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] DB_LO = 64'h0000_0000_CAFE_F00D;
    localparam logic [63:0] DC    = 64'h0C0C_0C0C_1234_5678;
    localparam logic [63:0] DD    = 64'hD0D0_D0D0_8765_4321;
    localparam logic [63:0] DE    = 64'hEEEE_1111_EEEE_1111;
    localparam logic [63:0] DF    = 64'hF00F_F00F_0FF0_0FF0;

    logic        CLK;
    logic        RESET;
    logic        r0_req, r0_lock, r0_write;
    logic [26:0] r0_addr;
    logic [63:0] r0_wdata;
    logic [7:0]  r0_wbe;
    logic        r1_req, r1_lock, r1_write;
    logic [26:0] r1_addr;
    logic [63:0] r1_wdata;
    logic [7:0]  r1_wbe;
    logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [63:0] r0_rdata, r1_rdata;
    logic        sram_cs;
    logic [7:0]  sram_we;
    logic [26:0] sram_addr;
    logic [63:0] sram_wdata;
    logic [63:0] sram_rdata;

    logic [63:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  p0;
        logic [7:0]  a0;
        logic [63:0] d0;
        logic [7:0]  b0;
        logic [2:0]  p1;
        logic [7:0]  a1;
        logic [63:0] d1;
        logic [7:0]  b1;
        logic [1:0]  e_gnt;
        logic [7:0]  e_we;
        logic [7:0]  e_addr;
        logic [1:0]  e_rv;
        logic [63:0] e_rdata;
    } vec_t;

    vec_t vecs [0:15];

    tlx_sram_arb dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .R0_REQ     (r0_req),
        .R0_LOCK    (r0_lock),
        .R0_WRITE   (r0_write),
        .R0_ADDR    (r0_addr),
        .R0_WDATA   (r0_wdata),
        .R0_WBE     (r0_wbe),
        .R0_GNT     (r0_gnt),
        .R0_RVALID  (r0_rvalid),
        .R0_RDATA   (r0_rdata),
        .R1_REQ     (r1_req),
        .R1_LOCK    (r1_lock),
        .R1_WRITE   (r1_write),
        .R1_ADDR    (r1_addr),
        .R1_WDATA   (r1_wdata),
        .R1_WBE     (r1_wbe),
        .R1_GNT     (r1_gnt),
        .R1_RVALID  (r1_rvalid),
        .R1_RDATA   (r1_rdata),
        .SRAM_CS    (sram_cs),
        .SRAM_WE    (sram_we),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WDATA (sram_wdata),
        .SRAM_RDATA (sram_rdata)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Behavioural SRAM: byte-masked writes, registered read data.
    always @(posedge CLK) begin
        if (sram_cs) begin
            for (int b = 0; b < 8; b++) begin
                if (sram_we[b]) mem[sram_addr[7:0]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end
            sram_rdata <= mem[sram_addr[7:0]];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] p0, input logic [7:0] a0, input logic [63:0] d0,
                                input logic [7:0] b0, input logic [2:0] p1, input logic [7:0] a1,
                                input logic [63:0] d1, input logic [7:0] b1, input logic [1:0] g,
                                input logic [7:0] we, input logic [7:0] ea, input logic [1:0] rv,
                                input logic [63:0] rd);
        vec_t v;
        v.p0 = p0; v.a0 = a0; v.d0 = d0; v.b0 = b0;
        v.p1 = p1; v.a1 = a1; v.d1 = d1; v.b1 = b1;
        v.e_gnt = g; v.e_we = we; v.e_addr = ea; v.e_rv = rv; v.e_rdata = rd;
        return v;
    endfunction

    // p = {req, lock, write}
    task automatic drive(input logic [2:0] p0, input logic [7:0] a0, input logic [63:0] d0,
                         input logic [7:0] b0, input logic [2:0] p1, input logic [7:0] a1,
                         input logic [63:0] d1, input logic [7:0] b1);
        {r0_req, r0_lock, r0_write} = p0;
        r0_addr = 27'(a0); r0_wdata = d0; r0_wbe = b0;
        {r1_req, r1_lock, r1_write} = p1;
        r1_addr = 27'(a1); r1_wdata = d1; r1_wbe = b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        sram_rdata = '0;
        RESET = 1'b1;
        drive(3'b100, 8'h10, '0, 8'h00, 3'b100, 8'h20, '0, 8'h00);

        // Reset state, with both ports requesting reads
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst cs", 64'(sram_cs), 64'd0);
        check("rst we", 64'(sram_we), 64'd0);
        check("rst gnt0", 64'(r0_gnt), 64'd0);
        check("rst gnt1", 64'(r1_gnt), 64'd0);
        check("rst rvalid0", 64'(r0_rvalid), 64'd0);
        check("rst rvalid1", 64'(r1_rvalid), 64'd0);
        @(posedge CLK);
        #1;
        drive(3'b000, 8'h00, '0, 8'h00, 3'b000, 8'h00, '0, 8'h00);
        RESET = 1'b0;

        // Alternating writes, reads, a 4-write lock by R1, hold checks
        vecs[0]  = mk(3'b101, 8'h10, DA, 8'hFF, 3'b101, 8'h20, DB, 8'h0F, 2'b01, 8'hFF, 8'h10, 2'b00, '0);
        vecs[1]  = mk(3'b101, 8'h10, DA, 8'hFF, 3'b101, 8'h20, DB, 8'h0F, 2'b10, 8'h0F, 8'h20, 2'b00, '0);
        vecs[2]  = mk(3'b101, 8'h10, DA, 8'hFF, 3'b101, 8'h20, DB, 8'h0F, 2'b01, 8'hFF, 8'h10, 2'b00, '0);
        vecs[3]  = mk(3'b101, 8'h10, DA, 8'hFF, 3'b101, 8'h20, DB, 8'h0F, 2'b10, 8'h0F, 8'h20, 2'b00, '0);
        vecs[4]  = mk(3'b100, 8'h10, '0, 8'h00, 3'b000, 8'h00, '0, 8'h00, 2'b01, 8'h00, 8'h10, 2'b00, '0);
        vecs[5]  = mk(3'b000, 8'h00, '0, 8'h00, 3'b100, 8'h20, '0, 8'h00, 2'b10, 8'h00, 8'h20, 2'b01, DA);
        vecs[6]  = mk(3'b101, 8'h30, DC, 8'hFF, 3'b000, 8'h00, '0, 8'h00, 2'b01, 8'hFF, 8'h30, 2'b10, DB_LO);
        vecs[7]  = mk(3'b100, 8'h10, '0, 8'h00, 3'b111, 8'h40, DD, 8'hFF, 2'b10, 8'hFF, 8'h40, 2'b00, '0);
        vecs[8]  = mk(3'b100, 8'h10, '0, 8'h00, 3'b111, 8'h40, DD, 8'hFF, 2'b10, 8'hFF, 8'h40, 2'b00, '0);
        vecs[9]  = mk(3'b100, 8'h10, '0, 8'h00, 3'b111, 8'h40, DD, 8'hFF, 2'b10, 8'hFF, 8'h40, 2'b00, '0);
        vecs[10] = mk(3'b100, 8'h10, '0, 8'h00, 3'b101, 8'h40, DD, 8'hFF, 2'b10, 8'hFF, 8'h40, 2'b00, '0);
        vecs[11] = mk(3'b100, 8'h10, '0, 8'h00, 3'b101, 8'h40, DD, 8'hFF, 2'b01, 8'h00, 8'h10, 2'b00, '0);
        vecs[12] = mk(3'b100, 8'h10, '0, 8'h00, 3'b101, 8'h40, DD, 8'hFF, 2'b10, 8'hFF, 8'h40, 2'b01, DA);
        vecs[13] = mk(3'b100, 8'h10, '0, 8'h00, 3'b000, 8'h00, '0, 8'h00, 2'b01, 8'h00, 8'h10, 2'b00, '0);
        vecs[14] = mk(3'b000, 8'h00, '0, 8'h00, 3'b101, 8'h60, DE, 8'hFF, 2'b10, 8'hFF, 8'h60, 2'b01, DA);
        vecs[15] = mk(3'b000, 8'h77, '0, 8'h00, 3'b000, 8'h55, '0, 8'h00, 2'b00, 8'h00, 8'h77, 2'b00, '0);

        for (int i = 0; i < 16; i++) begin
            @(posedge CLK);
            #1;
            drive(vecs[i].p0, vecs[i].a0, vecs[i].d0, vecs[i].b0,
                  vecs[i].p1, vecs[i].a1, vecs[i].d1, vecs[i].b1);
            @(negedge CLK);
            check($sformatf("v%0d gnt0", i), 64'(r0_gnt), 64'(vecs[i].e_gnt[0]));
            check($sformatf("v%0d gnt1", i), 64'(r1_gnt), 64'(vecs[i].e_gnt[1]));
            check($sformatf("v%0d cs", i), 64'(sram_cs), 64'(|vecs[i].e_gnt));
            check($sformatf("v%0d we", i), 64'(sram_we), 64'(vecs[i].e_we));
            check($sformatf("v%0d addr", i), 64'(sram_addr), 64'(vecs[i].e_addr));
            check($sformatf("v%0d rvalid0", i), 64'(r0_rvalid), 64'(vecs[i].e_rv[0]));
            check($sformatf("v%0d rvalid1", i), 64'(r1_rvalid), 64'(vecs[i].e_rv[1]));
            if (vecs[i].e_rv[0]) check($sformatf("v%0d rdata0", i), r0_rdata, vecs[i].e_rdata);
            if (vecs[i].e_rv[1]) check($sformatf("v%0d rdata1", i), r1_rdata, vecs[i].e_rdata);
        end

        // R0 holds LOCK for 20 cycles against R1: 16 R0 grants, R1 in cycle 17, then R0 again
        for (int k = 1; k <= 20; k++) begin
            @(posedge CLK);
            #1;
            drive(3'b111, 8'h50, DF, 8'hFF, 3'b101, 8'h60, DE, 8'hFF);
            @(negedge CLK);
            check($sformatf("burst c%0d gnt0", k), 64'(r0_gnt), 64'(k != 17));
            check($sformatf("burst c%0d gnt1", k), 64'(r1_gnt), 64'(k == 17));
        end

        // Dropping REQ leaves LOCK0 without granting R1 in the same cycle
        @(posedge CLK);
        #1;
        drive(3'b000, 8'h00, '0, 8'h00, 3'b101, 8'h60, DE, 8'hFF);
        @(negedge CLK);
        check("unlock gnt0", 64'(r0_gnt), 64'd0);
        check("unlock gnt1", 64'(r1_gnt), 64'd0);

        // R1 locked read burst, then reset with a read in flight
        @(posedge CLK);
        #1;
        drive(3'b000, 8'h00, '0, 8'h00, 3'b110, 8'h20, '0, 8'h00);
        @(negedge CLK);
        check("lock1 entry gnt1", 64'(r1_gnt), 64'd1);
        @(posedge CLK);
        #1;
        drive(3'b100, 8'h10, '0, 8'h00, 3'b110, 8'h20, '0, 8'h00);
        @(negedge CLK);
        check("lock1 gnt0", 64'(r0_gnt), 64'd0);
        check("lock1 gnt1", 64'(r1_gnt), 64'd1);
        check("lock1 rvalid1", 64'(r1_rvalid), 64'd1);
        check("lock1 rdata1", r1_rdata, DB_LO);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        #1;
        check("mid rst rvalid1", 64'(r1_rvalid), 64'd0);
        check("mid rst cs", 64'(sram_cs), 64'd0);
        check("mid rst gnt1", 64'(r1_gnt), 64'd0);
        @(posedge CLK);
        #1;
        check("post edge rvalid1", 64'(r1_rvalid), 64'd0);
        check("post edge rvalid0", 64'(r0_rvalid), 64'd0);
        RESET = 1'b0;
        drive(3'b100, 8'h10, '0, 8'h00, 3'b110, 8'h20, '0, 8'h00);
        @(negedge CLK);
        check("post rst gnt0", 64'(r0_gnt), 64'd1);
        check("post rst gnt1", 64'(r1_gnt), 64'd0);
        @(posedge CLK);
        #1;
        drive(3'b000, 8'h00, '0, 8'h00, 3'b000, 8'h00, '0, 8'h00);
        @(negedge CLK);
        check("post rst rvalid0", 64'(r0_rvalid), 64'd1);
        check("post rst rdata0", r0_rdata, DA);
        check("post rst rvalid1", 64'(r1_rvalid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
